// File: rtl/serial_link_pkg.sv
// Shared link-layer constants and types for the serial link credit logic.
package serial_link_pkg;

  localparam int unsigned NumCredits = 8;

  // Wide enough to hold the full budget NumCredits, not just NumCredits-1.
  typedef logic [$clog2(NumCredits):0] credit_t;

endpackage

// File: rtl/fifo_v3.sv
// Register-based FIFO, non-fall-through: a pushed word is visible at data_o the next cycle.
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam int unsigned AddrDepth = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AddrDepth-1:0]  readPointerQ, readPointerD;
  logic [AddrDepth-1:0]  writePointerQ, writePointerD;
  logic [AddrDepth:0]    statusCntQ, statusCntD;
  logic [DATA_WIDTH-1:0] memQ [DEPTH];
  logic                  pushOk, popOk;

  assign full_o  = (statusCntQ == (AddrDepth + 1)'(DEPTH));
  assign empty_o = (statusCntQ == '0);
  assign pushOk  = push_i & ~full_o;
  assign popOk   = pop_i & ~empty_o;
  assign data_o  = memQ[readPointerQ];

  always_comb begin
    readPointerD  = readPointerQ;
    writePointerD = writePointerQ;
    statusCntD    = statusCntQ;
    if (pushOk) begin
      writePointerD = (writePointerQ == AddrDepth'(DEPTH - 1)) ? '0 : writePointerQ + 1'b1;
    end
    if (popOk) begin
      readPointerD = (readPointerQ == AddrDepth'(DEPTH - 1)) ? '0 : readPointerQ + 1'b1;
    end
    unique case ({pushOk, popOk})
      2'b10:   statusCntD = statusCntQ + 1'b1;
      2'b01:   statusCntD = statusCntQ - 1'b1;
      default: statusCntD = statusCntQ;
    endcase
    if (flush_i) begin
      readPointerD  = '0;
      writePointerD = '0;
      statusCntD    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      readPointerQ  <= '0;
      writePointerQ <= '0;
      statusCntQ    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) memQ[i] <= '0;
    end else begin
      readPointerQ  <= readPointerD;
      writePointerQ <= writePointerD;
      statusCntQ    <= statusCntD;
      if (pushOk) memQ[writePointerQ] <= data_i;
    end
  end

endmodule

// File: rtl/serial_link_credit_rx.sv
// Receive side of the credit-based serial link: flit buffer plus pending-credit bookkeeping
// that tells the local transmitter how many credits to hand back to the peer.
module serial_link_credit_rx
  import serial_link_pkg::credit_t;
#(
  parameter int unsigned DataWidth       = 64,
  parameter int unsigned NumCredits      = serial_link_pkg::NumCredits,
  parameter int unsigned ForceSendThresh = NumCredits - 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DataWidth-1:0] data_in_i,
  input  logic                 data_in_valid_i,
  output logic [DataWidth-1:0] data_out_o,
  output logic                 data_out_valid_o,
  input  logic                 data_out_ready_i,
  output credit_t              credits_to_send_o,
  input  logic                 credits_sent_i,
  output logic                 force_send_o,
  output logic                 overflow_o
);

  logic    fifoFull, fifoEmpty;
  logic    pushEn, popEn;
  credit_t creditCntQ, creditCntD;
  logic    overflowQ, overflowD;

  // A full buffer drops the flit even if a pop happens in the same cycle.
  assign pushEn = data_in_valid_i & ~fifoFull;
  assign popEn  = data_out_ready_i & ~fifoEmpty;

  fifo_v3 #(
    .DATA_WIDTH (DataWidth),
    .DEPTH      (NumCredits)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .data_i  (data_in_i),
    .push_i  (pushEn),
    .data_o  (data_out_o),
    .pop_i   (popEn)
  );

  always_comb begin
    creditCntD = creditCntQ;
    overflowD  = overflowQ | (data_in_valid_i & fifoFull);
    // The credit freed by a coincident pop survives the handover to the transmitter.
    if (credits_sent_i) begin
      creditCntD = popEn ? credit_t'(1) : '0;
    end else if (popEn && (creditCntQ < credit_t'(NumCredits))) begin
      creditCntD = creditCntQ + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      creditCntQ <= '0;
      overflowQ  <= 1'b0;
    end else begin
      creditCntQ <= creditCntD;
      overflowQ  <= overflowD;
    end
  end

  assign data_out_valid_o  = ~fifoEmpty;
  assign credits_to_send_o = creditCntQ;
  assign force_send_o      = (creditCntQ >= credit_t'(ForceSendThresh));
  assign overflow_o        = overflowQ;

`ifndef SYNTHESIS
  a_credit_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    creditCntQ <= credit_t'(NumCredits));
`endif

endmodule
